cp0_unit: RTL and testbench
===========================

# cp0_unit

Coprocessor-0 for the pipelined MIPS core: the receiving end of the device interrupt lines (timer IRQ and the other bridge devices) and of synchronous exceptions raised by the pipeline. It holds SR, Cause, EPC and PRId, arbitrates interrupts against exceptions, and asserts a single request that flushes the pipeline. It also captures the restart PC and serves mfc0/mtc0/eret. It sits beside the M stage; the system bridge drives HWInt.

## Interface
- PRID, 32'h2015_0001, value returned for PRId (reg 15)
- CLK_I  in  1  clock, all state updates on rising edge
- RST_I  in  1  reset, asynchronous, active-high; clock CLK_I
- A1  in  5  mfc0 read register index
- A2  in  5  mtc0 write register index
- DIN  in  32  mtc0 write data
- WE  in  1  mtc0 write enable (M stage)
- PC  in  32  PC of the instruction currently in M
- BD_in  in  1  instruction in M is in a branch delay slot
- ExcCode_in  in  5  pipeline exception code for the M instruction, 0 = none
- EXLClr  in  1  eret in M
- HWInt  in  6  device interrupt lines [7:2]; bit 2 = timer 0, bit 3 = timer 1
- Req  out  1  exception/interrupt taken this cycle (combinational)
- EPC_out  out  32  current EPC, for eret target
- DOUT  out  32  mfc0 read data (combinational from A1)

## Operation
- SR (12): IM = bits [15:10], EXL = bit 1, IE = bit 0; all other bits read 0, writes to them ignored.
- Cause (13): BD = bit 31, IP = bits [15:10], ExcCode = bits [6:2]; other bits read 0. Read-only to mtc0.
- EPC (14): 32 bits, always held word-aligned ({x[31:2],2'b00}). PRId (15): constant PRID. Any other index reads 0.
- IntReq = |(HWInt & SR.IM) & SR.IE & ~SR.EXL.
- ExcReq = (ExcCode_in != 0) & ~SR.EXL.
- Req = IntReq | ExcReq. Interrupt has priority over exception.
- On a rising edge with Req=1:
  - EXL <= 1.
  - Cause.ExcCode <= IntReq ? 0 : ExcCode_in.
  - Cause.BD <= BD_in.
  - EPC <= BD_in ? PC-4 : PC, then word-aligned.
- IP register: Cause.IP <= HWInt every cycle, regardless of masks or EXL.
- mtc0: WE=1 with Req=0 writes SR (IM, EXL, IE from DIN[15:10], DIN[1], DIN[0]) or EPC (DIN word-aligned). Writes to Cause, PRId or other indices are ignored.
- eret: EXLClr=1 with Req=0 clears EXL. EXL forms the 2-state controller NORMAL (EXL=0) / HANDLER (EXL=1). NORMAL→HANDLER on Req; HANDLER→NORMAL on EXLClr or an mtc0 write to SR with DIN[1]=0.
- Width rules: PC-4 is a 32-bit wrap-around subtract (PC=0 with BD gives 32'hFFFF_FFFC before alignment → 32'hFFFF_FFFC).

## Timing
- Reset: SR=0, Cause=0, EPC=0. Outputs after reset: Req=0, EPC_out=0, DOUT=0 for every index except 15.
- Reset asserted mid-handler clears EXL immediately; no pending state survives.
- Req is combinational the same cycle HWInt/ExcCode_in qualify; the state update lands on the next edge. Req is 0 in the cycle after being taken, because EXL=1.
- HWInt is level-sensitive, not latched. A pulse that falls before IE/IM/EXL permit is lost, except in Cause.IP, which shows it one cycle later.
- Simultaneous events:
  - Req with WE: the mtc0 is dropped; Req updates win.
  - Req with EXLClr: cannot occur, since EXL=1 forces Req=0.
  - WE to SR with EXLClr: the write is applied, then EXL is cleared. EXLClr has final say on EXL.
- Read-during-write: DOUT and EPC_out show the old value in the write cycle and the new value from the next cycle.

## Test plan
- Reset, then read indices 12/13/14/15/7 → 0, 0, 0, 32'h2015_0001, 0; Req=0 with HWInt=6'h3F.
- mtc0 SR=32'h0000_0401 (IM[10] and IE set), PC=32'h0000_3010, HWInt[2] rises → Req=1 same cycle. After the edge: EPC=32'h0000_3010, Cause.ExcCode=0, IP[10]=1, EXL=1, and Req drops.
- ExcCode_in=5'd4, BD_in=1, PC=32'h0000_3024, IE=0 → Req=1. After the edge: EPC=32'h0000_3020, Cause=32'h8000_0010 (plus IP bits), EXL=1.
- HWInt[3] high with IM[11]=0 → Req stays 0 and Cause.IP[11] reads 1. mtc0 SR setting IM[11] → Req=1 the next cycle.
- In the handler, HWInt[2] high → Req=0. EXLClr → EXL=0 next cycle and Req=1 the following cycle, while the line is still high.
- Req and mtc0 EPC=32'h1234_5678 in the same cycle → EPC holds the exception PC, not 32'h1234_5678. Separately, mtc0 EPC=32'h1234_5677 → reads 32'h1234_5674.

Source files
------------

// File: rtl/cp0_unit.sv
// Coprocessor 0: SR/Cause/EPC/PRId, interrupt vs. exception arbitration,
// restart-PC capture and the mfc0/mtc0/eret datapath beside the M stage.
module cp0_unit #(
    parameter logic [31:0] PRID = 32'h2015_0001
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIN,
    input  logic        WE,
    input  logic [31:0] PC,
    input  logic        BD_in,
    input  logic [4:0]  ExcCode_in,
    input  logic        EXLClr,
    input  logic [5:0]  HWInt,
    output logic        Req,
    output logic [31:0] EPC_out,
    output logic [31:0] DOUT
);

    // EXL is held as the controller state: NORMAL = 0, HANDLER = 1
    typedef enum logic {
        ST_NORMAL  = 1'b0,
        ST_HANDLER = 1'b1
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [5:0]  r_im;
    logic        r_ie;
    logic [5:0]  r_ip;
    logic        r_bd;
    logic [4:0]  r_exccode;
    logic [31:0] r_epc;

    logic        w_exl;
    logic        w_int_req;
    logic        w_exc_req;
    logic        w_sr_we;
    logic        w_epc_we;
    logic [31:0] w_epc_raw;

    assign w_exl     = (r_state == ST_HANDLER);
    assign w_int_req = (|(HWInt & r_im)) & r_ie & ~w_exl;
    assign w_exc_req = (ExcCode_in != 5'd0) & ~w_exl;
    assign Req       = w_int_req | w_exc_req;

    // A taken request swallows any mtc0 in the same cycle
    assign w_sr_we   = WE & ~Req & (A2 == 5'd12);
    assign w_epc_we  = WE & ~Req & (A2 == 5'd14);
    assign w_epc_raw = BD_in ? (PC - 32'd4) : PC;

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            r_state <= ST_NORMAL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // EXLClr is evaluated after the SR write so eret has the final say on EXL
    always_comb begin
        w_state_nxt = r_state;
        if (Req) begin
            w_state_nxt = ST_HANDLER;
        end else begin
            if (w_sr_we) begin
                w_state_nxt = DIN[1] ? ST_HANDLER : ST_NORMAL;
            end
            if (EXLClr) begin
                w_state_nxt = ST_NORMAL;
            end
        end
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            r_im      <= '0;
            r_ie      <= 1'b0;
            r_ip      <= '0;
            r_bd      <= 1'b0;
            r_exccode <= '0;
            r_epc     <= '0;
        end else begin
            r_ip <= HWInt;
            if (Req) begin
                r_exccode <= w_int_req ? 5'd0 : ExcCode_in;
                r_bd      <= BD_in;
                r_epc     <= {w_epc_raw[31:2], 2'b00};
            end else begin
                if (w_sr_we) begin
                    r_im <= DIN[15:10];
                    r_ie <= DIN[0];
                end
                if (w_epc_we) begin
                    r_epc <= {DIN[31:2], 2'b00};
                end
            end
        end
    end

    assign EPC_out = r_epc;

    always_comb begin
        DOUT = '0;
        case (A1)
            5'd12:   DOUT = {16'd0, r_im, 8'd0, w_exl, r_ie};
            5'd13:   DOUT = {r_bd, 15'd0, r_ip, 3'd0, r_exccode, 2'b00};
            5'd14:   DOUT = r_epc;
            5'd15:   DOUT = PRID;
            default: DOUT = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_unit.sv
// Self-checking bench for cp0_unit: per-cycle vector table with a scoreboard
// queue, plus a hand-written asynchronous-reset-in-handler sequence.
module tb_cp0_unit;

    logic        CLK_I;
    logic        RST_I;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] DIN;
    logic        WE;
    logic [31:0] PC;
    logic        BD_in;
    logic [4:0]  ExcCode_in;
    logic        EXLClr;
    logic [5:0]  HWInt;
    logic        Req;
    logic [31:0] EPC_out;
    logic [31:0] DOUT;

    cp0_unit #(.PRID(32'h2015_0001)) dut (
        .CLK_I      (CLK_I),
        .RST_I      (RST_I),
        .A1         (A1),
        .A2         (A2),
        .DIN        (DIN),
        .WE         (WE),
        .PC         (PC),
        .BD_in      (BD_in),
        .ExcCode_in (ExcCode_in),
        .EXLClr     (EXLClr),
        .HWInt      (HWInt),
        .Req        (Req),
        .EPC_out    (EPC_out),
        .DOUT       (DOUT)
    );

    initial CLK_I = 1'b0;
    always #5 CLK_I = ~CLK_I;

    typedef struct {
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] din;
        logic        we;
        logic [31:0] pc;
        logic        bd;
        logic [4:0]  exc;
        logic        eclr;
        logic [5:0]  hw;
        logic        exp_req;
        logic [31:0] exp_dout;
        logic [31:0] exp_epc;
    } vec_t;

    typedef struct {
        int          idx;
        logic        req;
        logic [31:0] dout;
        logic [31:0] epc;
    } exp_t;

    localparam int unsigned NVEC = 25;
    vec_t vecs[NVEC];
    exp_t sb[$];
    exp_t e;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic vec_t mk(input logic [4:0] a1, input logic [4:0] a2,
                                input logic [31:0] din, input logic we,
                                input logic [31:0] pc, input logic bd,
                                input logic [4:0] exc, input logic eclr,
                                input logic [5:0] hw, input logic req,
                                input logic [31:0] dout, input logic [31:0] epc);
        vec_t v;
        v.a1 = a1; v.a2 = a2; v.din = din; v.we = we; v.pc = pc; v.bd = bd;
        v.exc = exc; v.eclr = eclr; v.hw = hw;
        v.exp_req = req; v.exp_dout = dout; v.exp_epc = epc;
        return v;
    endfunction

    task automatic check32(input string name, input int idx,
                           input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive_idle();
        A1 = 5'd0; A2 = 5'd0; DIN = '0; WE = 1'b0; PC = '0;
        BD_in = 1'b0; ExcCode_in = 5'd0; EXLClr = 1'b0; HWInt = 6'd0;
    endtask

    initial begin
        //            a1  a2  din           we  pc            bd exc eclr hw     req dout          epc
        vecs[0]  = mk(12, 0,  32'h0,        0,  32'h0,        0, 0,  0,   6'h00, 0,  32'h0,        32'h0);
        vecs[1]  = mk(13, 0,  32'h0,        0,  32'h0,        0, 0,  0,   6'h00, 0,  32'h0,        32'h0);
        vecs[2]  = mk(14, 0,  32'h0,        0,  32'h0,        0, 0,  0,   6'h00, 0,  32'h0,        32'h0);
        vecs[3]  = mk(15, 0,  32'h0,        0,  32'h0,        0, 0,  0,   6'h00, 0,  32'h2015_0001, 32'h0);
        vecs[4]  = mk(7,  0,  32'h0,        0,  32'h0,        0, 0,  0,   6'h3F, 0,  32'h0,        32'h0);
        vecs[5]  = mk(13, 12, 32'h0000_0401, 1, 32'h0,        0, 0,  0,   6'h00, 0,  32'h0000_FC00, 32'h0);
        vecs[6]  = mk(12, 0,  32'h0,        0,  32'h0000_3010, 0, 0, 0,   6'h01, 1,  32'h0000_0401, 32'h0);
        vecs[7]  = mk(13, 0,  32'h0,        0,  32'h0,        0, 0,  0,   6'h01, 0,  32'h0000_0400, 32'h0000_3010);
        vecs[8]  = mk(12, 0,  32'h0,        0,  32'h0,        0, 0,  0,   6'h01, 0,  32'h0000_0403, 32'h0000_3010);
        vecs[9]  = mk(14, 0,  32'h0,        0,  32'h0,        0, 0,  1,   6'h01, 0,  32'h0000_3010, 32'h0000_3010);
        vecs[10] = mk(12, 0,  32'h0,        0,  32'h0000_3040, 0, 0, 0,   6'h01, 1,  32'h0000_0401, 32'h0000_3010);
        vecs[11] = mk(14, 12, 32'h0,        1,  32'h0,        0, 0,  0,   6'h00, 0,  32'h0000_3040, 32'h0000_3040);
        vecs[12] = mk(12, 14, 32'h1234_5678, 1, 32'h0000_3024, 1, 4, 0,   6'h00, 1,  32'h0,        32'h0000_3040);
        vecs[13] = mk(13, 0,  32'h0,        0,  32'h0,        0, 0,  0,   6'h00, 0,  32'h8000_0010, 32'h0000_3020);
        vecs[14] = mk(14, 12, 32'h0000_0803, 1, 32'h0,        0, 0,  1,   6'h02, 0,  32'h0000_3020, 32'h0000_3020);
        vecs[15] = mk(12, 0,  32'h0,        0,  32'h0,        1, 0,  0,   6'h02, 1,  32'h0000_0801, 32'h0000_3020);
        vecs[16] = mk(14, 0,  32'h0,        0,  32'h0,        0, 0,  0,   6'h00, 0,  32'hFFFF_FFFC, 32'hFFFF_FFFC);
        vecs[17] = mk(13, 12, 32'h0,        1,  32'h0,        0, 0,  0,   6'h00, 0,  32'h8000_0000, 32'hFFFF_FFFC);
        vecs[18] = mk(12, 0,  32'h0,        0,  32'h0,        0, 0,  0,   6'h02, 0,  32'h0,        32'hFFFF_FFFC);
        vecs[19] = mk(13, 12, 32'h0000_0801, 1, 32'h0,        0, 0,  0,   6'h02, 0,  32'h8000_0800, 32'hFFFF_FFFC);
        vecs[20] = mk(12, 0,  32'h0,        0,  32'h0000_4000, 0, 0, 0,   6'h02, 1,  32'h0000_0801, 32'hFFFF_FFFC);
        vecs[21] = mk(14, 14, 32'h1234_5677, 1, 32'h0,        0, 0,  0,   6'h00, 0,  32'h0000_4000, 32'h0000_4000);
        vecs[22] = mk(14, 13, 32'hFFFF_FFFF, 1, 32'h0,        0, 0,  0,   6'h00, 0,  32'h1234_5674, 32'h1234_5674);
        vecs[23] = mk(13, 15, 32'h0,        1,  32'h0,        0, 0,  0,   6'h00, 0,  32'h0,        32'h1234_5674);
        vecs[24] = mk(15, 0,  32'h0,        0,  32'h0,        0, 0,  0,   6'h00, 0,  32'h2015_0001, 32'h1234_5674);

        drive_idle();
        RST_I = 1'b1;
        repeat (2) @(posedge CLK_I);
        #2 RST_I = 1'b0;

        for (int unsigned i = 0; i < NVEC; i++) begin
            @(posedge CLK_I);
            #1;
            A1 = vecs[i].a1; A2 = vecs[i].a2; DIN = vecs[i].din; WE = vecs[i].we;
            PC = vecs[i].pc; BD_in = vecs[i].bd; ExcCode_in = vecs[i].exc;
            EXLClr = vecs[i].eclr; HWInt = vecs[i].hw;
            sb.push_back('{idx: int'(i), req: vecs[i].exp_req,
                           dout: vecs[i].exp_dout, epc: vecs[i].exp_epc});
            @(negedge CLK_I);
            if (sb.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL scoreboard [%0d]: queue empty, expected one entry", i);
            end else begin
                e = sb.pop_front();
                check32("Req",     e.idx, {31'd0, Req}, {31'd0, e.req});
                check32("DOUT",    e.idx, DOUT,         e.dout);
                check32("EPC_out", e.idx, EPC_out,      e.epc);
            end
        end

        // Asynchronous reset while in the handler (SR = IM[11], EXL, IE)
        @(posedge CLK_I);
        #1;
        drive_idle();
        A1 = 5'd12;
        #1;
        check32("SR_pre_reset", 100, DOUT, 32'h0000_0803);
        #1 RST_I = 1'b1;
        #1;
        check32("SR_async_reset",  101, DOUT,         32'h0);
        check32("EPC_async_reset", 102, EPC_out,      32'h0);
        check32("Req_async_reset", 103, {31'd0, Req}, 32'h0);
        @(negedge CLK_I);
        RST_I = 1'b0;

        // EXL must be clear: an exception is taken immediately
        @(posedge CLK_I);
        #1;
        ExcCode_in = 5'd5;
        PC = 32'h0000_5006;
        @(negedge CLK_I);
        check32("Req_exc_after_reset", 104, {31'd0, Req}, 32'h1);
        @(posedge CLK_I);
        #1;
        ExcCode_in = 5'd0;
        A1 = 5'd13;
        @(negedge CLK_I);
        check32("Cause_after_exc", 105, DOUT,    32'h0000_0014);
        check32("EPC_after_exc",   106, EPC_out, 32'h0000_5004);
        check32("Req_in_handler",  107, {31'd0, Req}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
